// File: rtl/alt_seq_pkg.sv
// Shared types and helpers for the alternating-bit stream generator.
// Holds the FSM encoding plus the bit-sequencing and verdict rules.
package alt_seq_pkg;

   localparam int unsigned LEN_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Wide enough for any LEN_W instance; callers zero-extend.
   typedef logic [31:0] idx_t;

   function automatic logic next_bit(
      input logic prev,
      input idx_t idx,
      input logic inj_en,
      input idx_t inj_pos
   );
      return (inj_en && (idx == inj_pos)) ? prev : ~prev;
   endfunction

   // Index 0 cannot corrupt (checker ignores it) and indices >= len never appear.
   function automatic logic expect_ok_calc(
      input idx_t len,
      input logic inj_en,
      input idx_t inj_pos
   );
      return !(inj_en && (inj_pos >= 32'd1) && (inj_pos < len));
   endfunction

endpackage

// File: rtl/alt_seq_gen.sv
// Alternating-bit serial source with optional single-bit repeat injection.
// Also predicts the verdict a downstream alternation checker should give.
module alt_seq_gen
   import alt_seq_pkg::*;
#(
   parameter int unsigned LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             first_bit,
   input  logic             inj_en,
   input  logic [LEN_W-1:0] inj_pos,
   input  logic             out_ready,
   output logic             out_bit,
   output logic             out_valid,
   output logic [LEN_W-1:0] bit_idx,
   output logic             busy,
   output logic             done,
   output logic             expect_ok
);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             inj_en_q, inj_en_d;
   logic [LEN_W-1:0] inj_pos_q, inj_pos_d;
   logic             out_bit_q, out_bit_d;
   logic             out_valid_q, out_valid_d;
   logic [LEN_W-1:0] bit_idx_q, bit_idx_d;
   logic             expect_ok_q, expect_ok_d;

   logic [LEN_W-1:0] idx_inc;
   logic             xfer;
   logic             last_bit;

   assign idx_inc  = bit_idx_q + LEN_W'(1);
   assign xfer     = out_valid_q && out_ready;
   assign last_bit = (bit_idx_q == (len_q - LEN_W'(1)));

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      inj_en_d    = inj_en_q;
      inj_pos_d   = inj_pos_q;
      out_bit_d   = out_bit_q;
      out_valid_d = out_valid_q;
      bit_idx_d   = bit_idx_q;
      expect_ok_d = expect_ok_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d       = len;
               inj_en_d    = inj_en;
               inj_pos_d   = inj_pos;
               expect_ok_d = expect_ok_calc(32'(len), inj_en, 32'(inj_pos));
               if (len != '0) begin
                  state_d     = ST_RUN;
                  out_valid_d = 1'b1;
                  out_bit_d   = first_bit;
                  bit_idx_d   = '0;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            if (xfer) begin
               if (last_bit) begin
                  state_d     = ST_DONE;
                  out_valid_d = 1'b0;
                  out_bit_d   = 1'b0;
                  bit_idx_d   = '0;
               end else begin
                  bit_idx_d = idx_inc;
                  out_bit_d = next_bit(out_bit_q, 32'(idx_inc),
                                       inj_en_q, 32'(inj_pos_q));
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            bit_idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         inj_en_q    <= 1'b0;
         inj_pos_q   <= '0;
         out_bit_q   <= 1'b0;
         out_valid_q <= 1'b0;
         bit_idx_q   <= '0;
         expect_ok_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         inj_en_q    <= inj_en_d;
         inj_pos_q   <= inj_pos_d;
         out_bit_q   <= out_bit_d;
         out_valid_q <= out_valid_d;
         bit_idx_q   <= bit_idx_d;
         expect_ok_q <= expect_ok_d;
      end
   end

   assign out_bit   = out_bit_q;
   assign out_valid = out_valid_q;
   assign bit_idx   = bit_idx_q;
   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign expect_ok = expect_ok_q;

endmodule

// File: tb/tb_alt_seq_gen.sv
// Bench for alt_seq_gen: closed-form stream model plus a loopback checker model.
module tb_alt_seq_gen;

   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [LW-1:0] len;
   logic          first_bit;
   logic          inj_en;
   logic [LW-1:0] inj_pos;
   logic          out_ready;
   logic          out_bit;
   logic          out_valid;
   logic [LW-1:0] bit_idx;
   logic          busy;
   logic          done;
   logic          expect_ok;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alt_seq_gen #(.LEN_W(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .first_bit (first_bit),
      .inj_en    (inj_en),
      .inj_pos   (inj_pos),
      .out_ready (out_ready),
      .out_bit   (out_bit),
      .out_valid (out_valid),
      .bit_idx   (bit_idx),
      .busy      (busy),
      .done      (done),
      .expect_ok (expect_ok)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bit i alternates from fb; after a repeat at ip the parity shifts by one.
   function automatic bit model_bit(int i, bit fb, bit ie, int ip);
      if (ie && ip >= 1 && i >= ip)
         return fb ^ (((i - 1) % 2) != 0);
      return fb ^ ((i % 2) != 0);
   endfunction

   function automatic bit model_ok(int n, bit ie, int ip);
      return !(ie && ip >= 1 && ip < n);
   endfunction

   task automatic run_stream(input int n, input bit fb, input bit ie,
                             input int ip, input int stall_pct,
                             input int hold_idx, input bit mid_start);
      int idx = 0;
      int cyc = 0;
      int held = 0;
      bit rdy;
      bit cur;
      bit prev = 1'b0;
      bit ok = 1'b1;
      bit mid_done = 1'b0;
      bit eok;
      eok = model_ok(n, ie, ip);
      start     = 1'b1;
      len       = LW'(n);
      first_bit = fb;
      inj_en    = ie;
      inj_pos   = LW'(ip);
      out_ready = 1'($urandom_range(1));
      @(negedge clk);
      start = 1'b0;
      chk("expect_ok", 32'(expect_ok), 32'(eok));
      if (n == 0) begin
         chk("len0_valid", 32'(out_valid), 0);
         chk("len0_done", 32'(done), 1);
         chk("len0_busy", 32'(busy), 0);
      end else begin
         while (idx < n && cyc < 20 * n + 50) begin
            chk("valid", 32'(out_valid), 1);
            chk("busy", 32'(busy), 1);
            chk("done_early", 32'(done), 0);
            chk("bit", 32'(out_bit), 32'(model_bit(idx, fb, ie, ip)));
            chk("idx", 32'(bit_idx), idx);
            cur = out_bit;
            if (idx == hold_idx && held < 3) begin
               rdy = 1'b0;
               held++;
            end else begin
               rdy = ($urandom_range(99) >= stall_pct);
            end
            out_ready = rdy;
            if (mid_start && idx == 1 && !mid_done) begin
               start     = 1'b1;
               len       = LW'(n + 3);
               first_bit = !fb;
               inj_en    = 1'b1;
               inj_pos   = 8'd2;
               mid_done  = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (rdy) begin
               if (idx > 0 && cur == prev) ok = 1'b0;
               prev = cur;
               idx++;
            end
         end
         chk("bits_sent", idx, n);
         chk("end_valid", 32'(out_valid), 0);
         chk("end_done", 32'(done), 1);
         chk("end_busy", 32'(busy), 0);
         chk("end_idx", 32'(bit_idx), 0);
         chk("loopback", 32'(ok), 32'(eok));
      end
      out_ready = 1'($urandom_range(1));
      start     = 1'b1;
      len       = 8'd3;
      @(negedge clk);
      start = 1'b0;
      chk("done_once", 32'(done), 0);
      chk("start_in_done", 32'(busy), 0);
      chk("expect_hold", 32'(expect_ok), 32'(eok));
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      len       = '0;
      first_bit = 1'b0;
      inj_en    = 1'b0;
      inj_pos   = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_bit", 32'(out_bit), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_idx", 32'(bit_idx), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_eok", 32'(expect_ok), 1);
      rst = 1'b0;
      @(negedge clk);

      run_stream(6, 1'b1, 1'b0, 0, 0, -1, 1'b0);
      run_stream(5, 1'b0, 1'b1, 3, 0, -1, 1'b0);
      run_stream(4, 1'b1, 1'b1, 0, 0, -1, 1'b0);
      run_stream(4, 1'b1, 1'b1, 4, 0, -1, 1'b0);
      run_stream(0, 1'b0, 1'b0, 0, 0, -1, 1'b0);
      run_stream(0, 1'b1, 1'b1, 0, 0, -1, 1'b0);
      run_stream(4, 1'b0, 1'b0, 0, 0, 1, 1'b0);
      run_stream(6, 1'b1, 1'b0, 0, 0, -1, 1'b1);
      run_stream(1, 1'b1, 1'b1, 1, 0, -1, 1'b0);
      run_stream(255, 1'b0, 1'b1, 254, 0, -1, 1'b0);

      // Abort mid-stream: expect_ok was 0 before the reset.
      start     = 1'b1;
      len       = 8'd8;
      first_bit = 1'b0;
      inj_en    = 1'b1;
      inj_pos   = 8'd5;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_idx", 32'(bit_idx), 2);
      chk("pre_rst_eok", 32'(expect_ok), 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_valid", 32'(out_valid), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_idx", 32'(bit_idx), 0);
      chk("abort_eok", 32'(expect_ok), 1);
      chk("abort_done", 32'(done), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_done", 32'(done), 0);
      end

      // rst and start together: rst wins.
      rst   = 1'b1;
      start = 1'b1;
      len   = 8'd5;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      chk("rst_start_busy", 32'(busy), 0);
      chk("rst_start_valid", 32'(out_valid), 0);
      @(negedge clk);
      chk("rst_start_idle", 32'(busy), 0);
      chk("rst_start_done", 32'(done), 0);

      run_stream(8, 1'b1, 1'b0, 0, 0, -1, 1'b0);

      for (int k = 0; k < 30; k++) begin
         int n;
         n = ($urandom_range(3) == 0) ? int'($urandom_range(2))
                                      : int'($urandom_range(24));
         run_stream(n, 1'($urandom_range(1)), 1'($urandom_range(1)),
                    int'($urandom_range(n + 2)), 30, -1,
                    1'($urandom_range(1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
